// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared status, tuning-field and key codes for the clock datapath
package clock_pkg;

    // System state codes; every code not listed here is a run state.
    localparam logic [2:0] S_TUNESEL     = 3'd2;
    localparam logic [2:0] S_TUNING      = 3'd3;
    localparam logic [2:0] S_TUNEALARM   = 3'd4;
    localparam logic [2:0] S_ALARMTUNING = 3'd5;

    // Field selected for editing by the tuning-field selector.
    typedef enum logic [1:0] {
        T_NONE   = 2'd0,
        T_SECOND = 2'd1,
        T_MINUTE = 2'd2,
        T_HOUR   = 2'd3
    } tune_field_e;

    // Debounced key-release patterns.
    localparam logic [3:0] MV_LEFT  = 4'b1000;
    localparam logic [3:0] MV_RIGHT = 4'b0001;
    localparam logic [3:0] KEY_INC  = 4'b0100;
    localparam logic [3:0] KEY_DEC  = 4'b0010;

endpackage

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - modulo counter with edit inc/dec and a tick carry chain
module mod_counter #(
    parameter int          MOD     = 60,
    parameter int          W       = 6,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    input  logic         carry_in,
    output logic [W-1:0] value,
    output logic [W-1:0] nxt,
    output logic         carry_out
);

    localparam logic [W-1:0] TOP = W'(MOD - 1);

    logic in_range;
    assign in_range = (value <= TOP);

    // Next value: edits wrap in place without carry; the tick path carries out on MOD-1 -> 0.
    always_comb begin
        nxt       = value;
        carry_out = 1'b0;
        if (!in_range) begin
            if (inc || dec || carry_in) begin
                nxt = '0;
            end
        end else if (inc) begin
            nxt = (value == TOP) ? '0 : value + 1'b1;
        end else if (dec) begin
            nxt = (value == '0) ? TOP : value - 1'b1;
        end else if (carry_in) begin
            if (value == TOP) begin
                nxt       = '0;
                carry_out = 1'b1;
            end else begin
                nxt = value + 1'b1;
            end
        end
    end

    // Value register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= RST_VAL;
        end else begin
            value <= nxt;
        end
    end

endmodule

// File: rtl/time_tune_engine.sv
// rtl/time_tune_engine.sv - wall-clock and alarm registers with tick advance, field edits and alarm match
module time_tune_engine
    import clock_pkg::*;
#(
    parameter int ALARM_RST_H = 7,
    parameter int ALARM_RST_M = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sec_tick,
    input  logic [3:0] neg_keys_filtered,
    input  logic [2:0] sys_status,
    input  logic [1:0] tune_status,
    input  logic       alarm_en,
    output logic [4:0] time_h,
    output logic [5:0] time_m,
    output logic [5:0] time_s,
    output logic [4:0] alarm_h,
    output logic [5:0] alarm_m,
    output logic [5:0] alarm_s,
    output logic       alarm_hit,
    output logic       tick_restart
);

    logic       frozen;
    logic       tick_en;
    logic       key_inc;
    logic       key_dec;
    logic       time_edit;
    logic       alarm_edit;
    logic [2:0] field_sel;
    logic [2:0] t_inc;
    logic [2:0] t_dec;
    logic [2:0] a_inc;
    logic [2:0] a_dec;
    logic [2:0] prev_status;

    logic [4:0] nxt_time_h;
    logic [5:0] nxt_time_m;
    logic [5:0] nxt_time_s;
    logic [4:0] nxt_alarm_h;
    logic [5:0] nxt_alarm_m;
    logic [5:0] nxt_alarm_s;
    logic       s_carry;
    logic       m_carry;
    logic       h_carry;
    logic       as_carry;
    logic       am_carry;
    logic       ah_carry;
    logic       unused_carries;

    // Ticks are dropped, not queued, while time is being selected or edited.
    assign frozen     = (sys_status == S_TUNESEL) || (sys_status == S_TUNING);
    assign tick_en    = sec_tick && !frozen;
    assign key_inc    = (neg_keys_filtered == KEY_INC);
    assign key_dec    = (neg_keys_filtered == KEY_DEC);
    assign time_edit  = (sys_status == S_TUNING);
    assign alarm_edit = (sys_status == S_ALARMTUNING);

    // One-hot field select, bit 0 seconds, bit 1 minutes, bit 2 hours.
    always_comb begin
        field_sel = 3'b000;
        case (tune_status)
            T_SECOND: field_sel = 3'b001;
            T_MINUTE: field_sel = 3'b010;
            T_HOUR:   field_sel = 3'b100;
            default:  field_sel = 3'b000;
        endcase
    end

    assign t_inc = {3{time_edit  && key_inc}} & field_sel;
    assign t_dec = {3{time_edit  && key_dec}} & field_sel;
    assign a_inc = {3{alarm_edit && key_inc}} & field_sel;
    assign a_dec = {3{alarm_edit && key_dec}} & field_sel;

    mod_counter #(.MOD(60), .W(6), .RST_VAL(6'd0)) u_time_s (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (t_inc[0]),
        .dec       (t_dec[0]),
        .carry_in  (tick_en),
        .value     (time_s),
        .nxt       (nxt_time_s),
        .carry_out (s_carry)
    );

    mod_counter #(.MOD(60), .W(6), .RST_VAL(6'd0)) u_time_m (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (t_inc[1]),
        .dec       (t_dec[1]),
        .carry_in  (s_carry),
        .value     (time_m),
        .nxt       (nxt_time_m),
        .carry_out (m_carry)
    );

    mod_counter #(.MOD(24), .W(5), .RST_VAL(5'd0)) u_time_h (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (t_inc[2]),
        .dec       (t_dec[2]),
        .carry_in  (m_carry),
        .value     (time_h),
        .nxt       (nxt_time_h),
        .carry_out (h_carry)
    );

    mod_counter #(.MOD(60), .W(6), .RST_VAL(6'd0)) u_alarm_s (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (a_inc[0]),
        .dec       (a_dec[0]),
        .carry_in  (1'b0),
        .value     (alarm_s),
        .nxt       (nxt_alarm_s),
        .carry_out (as_carry)
    );

    mod_counter #(.MOD(60), .W(6), .RST_VAL(6'(ALARM_RST_M))) u_alarm_m (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (a_inc[1]),
        .dec       (a_dec[1]),
        .carry_in  (1'b0),
        .value     (alarm_m),
        .nxt       (nxt_alarm_m),
        .carry_out (am_carry)
    );

    mod_counter #(.MOD(24), .W(5), .RST_VAL(5'(ALARM_RST_H))) u_alarm_h (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (a_inc[2]),
        .dec       (a_dec[2]),
        .carry_in  (1'b0),
        .value     (alarm_h),
        .nxt       (nxt_alarm_h),
        .carry_out (ah_carry)
    );

    // Alarm registers never tick and the hour carry wraps the day silently.
    assign unused_carries = ^{h_carry, as_carry, am_carry, ah_carry};

    // Alarm match on the post-advance time; edits alone never reach this path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_hit <= 1'b0;
        end else begin
            alarm_hit <= tick_en && alarm_en &&
                         ({nxt_time_h, nxt_time_m, nxt_time_s} ==
                          {nxt_alarm_h, nxt_alarm_m, nxt_alarm_s});
        end
    end

    // Leaving time edit (except back to field select) restarts the prescaler's second boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_status  <= 3'd0;
            tick_restart <= 1'b0;
        end else begin
            prev_status  <= sys_status;
            tick_restart <= (prev_status == S_TUNING) &&
                            (sys_status != S_TUNING) &&
                            (sys_status != S_TUNESEL);
        end
    end

endmodule

// File: doc/time_tune_engine.md
# time_tune_engine

Holds the running wall-clock time and the alarm time, advances the clock on the 1 Hz tick, and applies increment/decrement edits to whichever field `tune_status` selects while the system is in a tuning state. Sits downstream of the tuning-field selector (consumes `tune_status` and `sys_status`) and upstream of the display mux and alarm logic. Also emits the alarm-match pulse and a prescaler-restart pulse when time editing ends.

## Interface
Parameters:
- `ALARM_RST_H`, 7: alarm hour after reset.
- `ALARM_RST_M`, 0: alarm minute after reset.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `sec_tick`  in  1  one-cycle pulse, once per second, from the prescaler.
- `neg_keys_filtered`  in  4  debounced key-release pulses; one cycle wide.
- `sys_status`  in  3  system state code.
- `tune_status`  in  2  selected field: 0 none, 1 second, 2 minute, 3 hour.
- `alarm_en`  in  1  alarm armed.
- `time_h`  out  5  clock hour, 0–23.
- `time_m`, `time_s`  out  6  each  clock minute/second, 0–59.
- `alarm_h`  out  5  alarm hour, 0–23.
- `alarm_m`, `alarm_s`  out  6  each  alarm minute/second, 0–59.
- `alarm_hit`  out  1  one-cycle pulse on alarm match.
- `tick_restart`  out  1  one-cycle pulse when time editing ends.

## Operation
- State codes: S_TUNESEL=2, S_TUNING=3, S_TUNEALARM=4, S_ALARMTUNING=5; all other codes are "run".
- Key codes in tuning states: KEY_INC=4'b0100, KEY_DEC=4'b0010. Any other pattern, including multi-hot, is ignored.
- Clock freeze: `sec_tick` is ignored while `sys_status` ∈ {S_TUNESEL, S_TUNING}. Ticks arriving during freeze are dropped, not queued. In all other states the clock advances.
- Clock advance: s+1. At 59, s wraps to 0 and m increments. At m 59, m wraps to 0 and h increments. At h 23, h wraps to 0.
- Time edit: in S_TUNING, INC/DEC acts on the `tune_status` field of the time registers. Wrap is modulo 60 (s, m) or 24 (h). There is no carry or borrow into other fields: 59+1 → 0, 0−1 → 59, h 0−1 → 23.
- Alarm edit: in S_ALARMTUNING, INC/DEC acts on the `tune_status` field of the alarm registers with the same modulo rules. The clock keeps ticking in parallel.
- `tune_status`=0 in a tuning state: key presses are ignored.
- Alarm registers never tick.
- Alarm match: `alarm_hit` pulses in the cycle after a clock advance when `alarm_en`=1 and the new (h,m,s) equals (alarm_h, alarm_m, alarm_s). Edits never raise `alarm_hit`.
- Tick restart: `tick_restart` pulses for one cycle when `sys_status` moves from S_TUNING to any state other than S_TUNESEL.
  - Detected with a registered copy of the previous `sys_status`.
  - The prescaler uses this pulse to restart the second boundary.
- Reset values: time 00:00:00; alarm ALARM_RST_H:ALARM_RST_M:00; `alarm_hit`=0; `tick_restart`=0; previous-status register=0.

## Timing
- All outputs are registered.
- An edit or tick seen at clock edge N is visible on the outputs after edge N.
- `alarm_hit` and `tick_restart` are asserted for exactly one cycle, in the cycle after the triggering edge.
- Key pulse coincident with `sec_tick`:
  - In S_TUNING the tick is dropped and the edit applies.
  - In S_ALARMTUNING both apply, to different registers.
- Reset mid-operation: all registers return to reset values immediately. A pending tick or key is lost.
- Out-of-range register values are impossible by construction. Nevertheless, any value ≥ modulus is forced to 0 on its next update.

## Structure
- Shared package `clock_pkg` holds:
  - the sys_status codes;
  - the T_NONE/T_SECOND/T_MINUTE/T_HOUR codes;
  - the MV_LEFT/MV_RIGHT/KEY_INC/KEY_DEC codes.
- These constants are shared with the field selector and the status manager.
- Sub-module `mod_counter` has parameters MOD and W, and inputs inc, dec, and carry_in. It outputs the value and a carry_out on its wrap from MOD−1 to 0. carry_out is used only on the tick path.
- It is instantiated six times: three for time, three for alarm.

## Test plan
- Reset, then 3 `sec_tick` in run state → time 00:00:03, `alarm_hit`=0, alarm 07:00:00.
- Preload time 23:59:59 by editing, then run with 1 tick → 00:00:00 with full carry chain.
- S_TUNING with `tune_status`=1 at s=59 → KEY_INC gives s=0 with m unchanged; KEY_DEC gives s=59. Ticks during S_TUNING leave time unchanged.
- S_ALARMTUNING with `tune_status`=3 at alarm_h=0 → KEY_DEC gives 23. A simultaneous `sec_tick` still advances time_s.
- Alarm 00:00:05 with `alarm_en`=1 → one-cycle `alarm_hit` after the tick reaching 00:00:05. No pulse when `alarm_en`=0 or when time is edited onto the alarm value.
- S_TUNING → run state → one-cycle `tick_restart`. S_TUNING → S_TUNESEL → no pulse. Reset asserted mid-edit → all outputs at reset values.
